ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic) to the keyboard and reports the device ACK bit.
- Sits beside the existing PS/2 receive path on the same PS2_CLK/PS2_DAT pins; drives both lines open-drain through low-enables.
- The 0xFA response byte is received by the receive path, not by this block.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_line_sync.sv | 16 +
 rtl/ps2_host_tx.sv | 106 ++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, frame constants and parity helper for the PS/2 host/receive paths.
package ps2_pkg;
   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, RELEASE, BITS, ACK, WAIT_IDLE} state_t;
   localparam int FRAME_LEN = 11;
   localparam int INHIBIT_CYCLES_DEF = 6000;
   localparam int TIMEOUT_CYCLES_DEF = 750000;
   localparam int MAX_RETRIES_DEF = 2;
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronisers for the PS/2 clk/dat pins plus a synced clock falling-edge strobe.
module ps2_line_sync (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic clk_in,
   input  logic dat_in,
   output logic clk_s,
   output logic dat_s,
   output logic fall
);
   logic clk_m, dat_m, clk_p;
   always_ff @(posedge CLOCK_50)
      if (reset) {clk_m, clk_s, clk_p, dat_m, dat_s} <= '1;
      else {clk_m, clk_s, clk_p, dat_m, dat_s} <= {clk_in, clk_m, clk_s, dat_in, dat_m};
   assign fall = clk_p & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain low-enables.
// Define PS2_TX_RETRY_EN to resend automatically on NACK or timeout (up to MAX_RETRIES).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef PS2_TX_RETRY_EN
   , parameter int MAX_RETRIES = MAX_RETRIES_DEF
`endif
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] send_data,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
   localparam int LAST_BIT = FRAME_LEN - 2;
   state_t state, state_next;
   logic [CW-1:0] cnt;
   logic [3:0] bit_cnt;
   logic [FRAME_LEN-2:0] sr;
   logic clk_s, dat_s, fall, timed, fall_t, expire, retry_ok, clk_oe_d, dat_oe_d;

   ps2_line_sync u_sync (
      .CLOCK_50(CLOCK_50), .reset(reset), .clk_in(ps2_clk_in), .dat_in(ps2_dat_in),
      .clk_s(clk_s), .dat_s(dat_s), .fall(fall)
   );

   // Only device-clocked states watch for edges; our own inhibit also produces a synced fall.
   assign timed = state inside {RELEASE, BITS, ACK, WAIT_IDLE};
   assign fall_t = timed && fall;
   assign expire = timed && !fall && cnt == CW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_RETRY_EN
   logic [7:0] attempts;
   assign retry_ok = attempts < 8'(MAX_RETRIES);
   always_ff @(posedge CLOCK_50)
      if (reset || (state == IDLE && send)) attempts <= '0;
      else if (state != INHIBIT && state_next == INHIBIT) attempts <= attempts + 1'b1;
`else
   assign retry_ok = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         sr <= '0;
         done <= 1'b0;
         ack_ok <= 1'b0;
         timeout <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         state <= state_next;
         cnt <= (fall_t || state == IDLE || state == RTS || (state != INHIBIT && state_next == INHIBIT)) ? '0 : cnt + 1'b1;
         bit_cnt <= state == BITS ? (fall ? (bit_cnt == 4'(LAST_BIT) ? 4'd0 : bit_cnt + 4'd1) : bit_cnt) : 4'd0;
         ps2_clk_oe <= clk_oe_d;
         ps2_dat_oe <= dat_oe_d;
         done <= state != IDLE && state_next == IDLE;
         if (state == IDLE && send) begin
            sr <= {1'b1, odd_parity(send_data), send_data};
            ack_ok <= 1'b0;
            timeout <= 1'b0;
         end else if (state == ACK && fall) ack_ok <= ~dat_s;
         else if (expire && state_next != state) begin
            ack_ok <= 1'b0;
            timeout <= !retry_ok;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      state_next = send ? INHIBIT : IDLE;
         INHIBIT:   state_next = cnt == CW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
         RTS:       state_next = RELEASE;
         RELEASE:   state_next = BITS;
         BITS:      state_next = fall && bit_cnt == 4'(LAST_BIT) ? ACK : BITS;
         ACK:       state_next = fall ? (dat_s && retry_ok ? INHIBIT : WAIT_IDLE) : ACK;
         WAIT_IDLE: state_next = clk_s && dat_s ? IDLE : WAIT_IDLE;
         default:   state_next = IDLE;
      endcase
      if (expire && state_next == state) state_next = retry_ok ? INHIBIT : IDLE;
   end

   always_comb begin
      ready = state == IDLE;
      busy = !ready;
      clk_oe_d = state_next inside {INHIBIT, RTS};
      dat_oe_d = state_next inside {RTS, RELEASE} ? 1'b1 :
                 state_next inside {BITS, ACK} ? (state == BITS && fall ? ~sr[bit_cnt] : ps2_dat_oe) : 1'b0;
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed plus randomized transactions against a PS/2 keyboard model.
module tb_ps2_host_tx;
   localparam int INH = 200;
   localparam int TO = 400;
`ifdef PS2_TX_RETRY_EN
   localparam int TRIES = 3;
`else
   localparam int TRIES = 1;
`endif
   logic CLOCK_50 = 0, reset = 1, send = 0;
   logic [7:0] send_data = 0;
   logic ready, busy, done, ack_ok, timeout, ps2_clk_oe, ps2_dat_oe;
   logic dev_clk = 0, dev_dat = 0;
   logic ps2_clk, ps2_dat;
   int total = 0, passed = 0, failed = 0;
   int cyc = 0, done_cnt = 0, frames = 0, inh_len = 0, rel_cyc = 0, done_cyc = 0;
   logic d_ack, d_to, d_oe, prev_clk_oe = 0;

   assign ps2_clk = ~(ps2_clk_oe | dev_clk);
   assign ps2_dat = ~(ps2_dat_oe | dev_dat);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .send(send), .send_data(send_data),
      .ready(ready), .busy(busy), .done(done), .ack_ok(ack_ok), .timeout(timeout),
      .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) begin
      cyc++;
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh_len++;
      if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) begin
         rel_cyc = cyc;
         frames++;
      end
      prev_clk_oe = ps2_clk_oe;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         d_ack = ack_ok;
         d_to = timeout;
         d_oe = ps2_clk_oe | ps2_dat_oe;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int ones = $countones(b);
      return {1'b1, ones % 2 == 0, b, 1'b0};
   endfunction

   task automatic do_send(input logic [7:0] b);
      @(negedge CLOCK_50);
      send_data = b;
      send = 1;
      @(negedge CLOCK_50);
      send = 0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int n = 0;
      while (done_cnt < target && n < 20000) begin
         @(negedge CLOCK_50);
         n++;
      end
      check({tag, "_dones"}, done_cnt, target);
   endtask

   // Keyboard model: waits for the host release, clocks 11 falls, samples data before each rise.
   task automatic device_frame(input logic do_ack, input int half, input int stop_after,
                               output logic [10:0] seen, output logic ok);
      int n = 0;
      seen = '0;
      ok = 1;
      while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && n < 5000) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (n >= 5000) ok = 0;
      repeat (half) @(negedge CLOCK_50);
      seen[0] = ps2_dat;
      for (int i = 1; i <= 10; i++) begin
         dev_clk = 1;
         repeat (half) @(negedge CLOCK_50);
         if (i == stop_after) return;
         seen[i] = ps2_dat;
         dev_clk = 0;
         repeat (half) @(negedge CLOCK_50);
      end
      dev_dat = do_ack;
      repeat (half) @(negedge CLOCK_50);
      dev_clk = 1;
      repeat (half) @(negedge CLOCK_50);
      dev_clk = 0;
      if (do_ack) begin
         repeat (8) @(negedge CLOCK_50);
         check("hold_busy", ready, 0);
         dev_dat = 0;
      end
   endtask

   task automatic run_txn(input logic [7:0] b, input logic do_ack, input int half, input string tag);
      int bd = done_cnt, bf = frames, bi = inh_len;
      int tries = do_ack ? 1 : TRIES;
      logic [10:0] seen;
      logic ok;
      do_send(b);
      for (int t = 0; t < tries; t++) device_frame(do_ack, half, 0, seen, ok);
      wait_done(bd + 1, tag);
      check({tag, "_release"}, ok, 1);
      check({tag, "_bits"}, seen, model_frame(b));
      check({tag, "_ack"}, d_ack, do_ack);
      check({tag, "_to"}, d_to, 0);
      check({tag, "_frames"}, frames - bf, tries);
      check({tag, "_inhibit"}, inh_len - bi, tries * INH);
      @(negedge CLOCK_50);
      check({tag, "_ready"}, ready, 1);
   endtask

   initial begin
      logic [10:0] seen;
      logic ok;
      int bd, bf, bi;
      repeat (3) @(negedge CLOCK_50);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_dat_oe", ps2_dat_oe, 0);
      check("rst_done", done, 0);
      check("rst_ack", ack_ok, 0);
      check("rst_to", timeout, 0);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      reset = 0;
      @(negedge CLOCK_50);
      reset = 1;
      send = 1;
      send_data = 8'hED;
      @(negedge CLOCK_50);
      reset = 0;
      send = 0;
      repeat (5) @(negedge CLOCK_50);
      check("rst_send_ready", ready, 1);

      run_txn(8'hED, 1, 20, "ed");
      run_txn(8'h00, 1, 12, "x00");
      run_txn(8'hFF, 1, 15, "xff");
      run_txn(8'h01, 1, 10, "x01");
      run_txn(8'h5A, 0, 12, "nack");

      bd = done_cnt;
      bf = frames;
      do_send(8'h12);
      wait_done(bd + 1, "tmo");
      check("tmo_flag", d_to, 1);
      check("tmo_ack", d_ack, 0);
      check("tmo_oe", d_oe, 0);
      check("tmo_latency", done_cyc - rel_cyc, TO);
      check("tmo_frames", frames - bf, TRIES);

      do_send(8'h9C);
      device_frame(1, 12, 5, seen, ok);
      bd = done_cnt;
      reset = 1;
      @(negedge CLOCK_50);
      reset = 0;
      check("mid_rst_clk_oe", ps2_clk_oe, 0);
      check("mid_rst_dat_oe", ps2_dat_oe, 0);
      check("mid_rst_ready", ready, 1);
      dev_clk = 0;
      repeat (30) @(negedge CLOCK_50);
      check("mid_rst_no_done", done_cnt, bd);
      run_txn(8'hF4, 1, 12, "f4");

      bd = done_cnt;
      bf = frames;
      do_send(8'hA3);
      repeat (20) @(negedge CLOCK_50);
      check("ign_busy", busy, 1);
      send_data = 8'h55;
      send = 1;
      @(negedge CLOCK_50);
      send = 0;
      device_frame(1, 12, 0, seen, ok);
      wait_done(bd + 1, "ign");
      check("ign_bits", seen, model_frame(8'hA3));
      check("ign_frames", frames - bf, 1);

      for (int k = 0; k < 4; k++)
         run_txn(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(8, 20), $sformatf("rnd%0d", k));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
